// File: rtl/ahb_sram_slv_if.sv
// ahb_sram_slv_if: AHB bus signals between a master and the ahb_sram_slv SRAM slave.
// Master side drives hsel/haddr/htrans/hwrite/hsize/hburst/hwdata/hready;
// slave side returns hreadyout/hresp/hrdata.
interface ahb_sram_slv_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slv.sv
// ahb_sram_slv: AHB slave with a word-organised register-array memory and programmable wait states.
// Ports: clk (rising edge), rst (synchronous, active-high), s (ahb_sram_slv_if.slave bus signals).
// Build option: define AHB_SRAM_SLV_ERR_EN to answer illegal accesses with a two-cycle ERROR;
// without it HRESP is always OKAY, addresses wrap and odd sizes/alignments use the raw lanes.
module ahb_sram_slv #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic           clk,
    input logic           rst,
    ahb_sram_slv_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          act_q, act_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   mem [DEPTH];
    logic          accept, illegal, ready, done;
    logic [3:0]    be;
    logic          unused;
    assign unused = &{1'b0, s.hburst, s.htrans[0], s.haddr};
    assign accept = s.hsel & s.hready & s.htrans[1];
`ifdef AHB_SRAM_SLV_ERR_EN
    assign illegal = s.haddr >= 32'(4 * DEPTH) || s.hsize > 3'd2 ||
                     (s.hsize == 3'd1 && s.haddr[0]) ||
                     (s.hsize == 3'd2 && s.haddr[1:0] != 2'b00);
    assign s.hresp = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
`else
    assign illegal = 1'b0;
    assign s.hresp = 2'b00;
`endif
    assign ready  = state_q == WAIT ? cnt_q == 4'd0 : state_q != ERR1;
    // act_q is only ever set for legal transfers, so it marks a live OKAY data phase
    assign done   = act_q & ready;
    assign be     = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                    size_q == 3'd1 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    assign s.hreadyout = ready;
    assign s.hrdata    = act_q & ~wr_q ? mem[addr_q[AW+1:2]] : 32'h0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        if (state_q == ERR1)
            state_d = ERR2;
        else if (state_q == ERR2) begin
            // a master must cancel its address phase during the second ERROR cycle
            state_d = IDLE;
            act_d   = 1'b0;
        end else if (!ready)
            cnt_d = cnt_q - 4'd1;
        else begin
            // completing (or idle) cycle: a new address phase here is pipelined normally
            act_d   = accept & ~illegal;
            state_d = !accept ? IDLE : illegal ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
            cnt_d   = 4'(WAIT_STATES);
            if (accept) begin
                addr_d = s.haddr[AW+1:0];
                wr_d   = s.hwrite;
                size_d = s.hsize;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            act_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
        end
    end
    // memory is not reset; a reset edge suppresses the pending write
    always_ff @(posedge clk) begin
        if (!rst && done && wr_q)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[addr_q[AW+1:2]][8*i +: 8] <= s.hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slv.sv
// tb_ahb_sram_slv: self-checking bench for ahb_sram_slv, one instance with 0 and one with 3 wait states.
module tb_ahb_sram_slv;
    localparam int DEPTH = 256;
`ifdef AHB_SRAM_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] w;
        logic [31:0] rd;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst    [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic        rdy    [2];
    logic [1:0]  resp   [2];
    logic [31:0] rdata  [2];
    logic [31:0] mem_m  [2][DEPTH];
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    genvar g;
    for (g = 0; g < 2; g++) begin : gen_dut
        ahb_sram_slv_if bus ();
        assign bus.hsel   = hsel[g];
        assign bus.haddr  = haddr[g];
        assign bus.htrans = htrans[g];
        assign bus.hwrite = hwrite[g];
        assign bus.hsize  = hsize[g];
        assign bus.hburst = 3'b001;
        assign bus.hwdata = hwdata[g];
        assign bus.hready = bus.hreadyout;
        assign rdy[g]     = bus.hreadyout;
        assign resp[g]    = bus.hresp;
        assign rdata[g]   = bus.hrdata;
        ahb_sram_slv #(.DEPTH(DEPTH), .WAIT_STATES(g * 3)) dut (
            .clk(clk),
            .rst(rst[g]),
            .s(bus)
        );
    end
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic bit is_err(logic [31:0] a, logic [2:0] s);
        return ERR_EN && (a >= 4 * DEPTH || s > 2 || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0));
    endfunction
    function automatic logic [31:0] mread(int d, logic [31:0] a);
        return mem_m[d][int'((a / 4) % DEPTH)];
    endfunction
    function automatic void mwrite(int d, logic [31:0] a, logic [2:0] s, logic [31:0] w);
        int idx = int'((a / 4) % DEPTH);
        int lo  = s >= 2 ? 0 : int'(a % 4);
        int n   = s == 0 ? 1 : s == 1 ? 2 : 4;
        for (int b = lo; b < lo + n && b < 4; b++)
            mem_m[d][idx][8*b +: 8] = w[8*b +: 8];
    endfunction
    task automatic idle_bus(int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask
    task automatic xfer(int d, bit wr, logic [31:0] a, logic [2:0] s, logic [31:0] w,
                        logic [31:0] exp_rd, string nm);
        bit         err = is_err(a, s);
        logic [1:0] r0;
        int         lows = 0;
        @(negedge clk);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = s;
        @(negedge clk);
        idle_bus(d);
        hwdata[d] = w;
        r0 = resp[d];
        while (!rdy[d] && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        chk({nm, " ready"}, 32'(rdy[d]), 32'd1);
        chk({nm, " wait cycles"}, lows, err ? 1 : d * 3);
        chk({nm, " resp pair"}, {r0, resp[d]}, err ? 32'h5 : 32'h0);
        if (!err) chk({nm, " rdata"}, rdata[d], exp_rd);
        if (wr && !err) mwrite(d, a, s, w);
    endtask
    task automatic burst(int d);
        int cyc = 0;
        int lows;
        @(negedge clk);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = 32'h40; hwrite[d] = 1'b0; hsize[d] = 3'd2;
        @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            if (b < 3) begin
                htrans[d] = 2'b11;
                haddr[d]  = 32'h40 + 32'(4 * (b + 1));
            end else
                idle_bus(d);
            lows = 0;
            cyc++;
            while (!rdy[d] && lows < 40) begin
                lows++;
                cyc++;
                @(negedge clk);
            end
            chk("burst beat wait", lows, d * 3);
            chk("burst beat resp", resp[d], 0);
            chk("burst beat rdata", rdata[d], mread(d, 32'h40 + 32'(4 * b)));
            @(negedge clk);
        end
        chk("burst total cycles", cyc, 4 * (d * 3 + 1));
    endtask
    task automatic b2b(int d);
        int lows = 0;
        @(negedge clk);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = 32'h8; hwrite[d] = 1'b1; hsize[d] = 3'd2;
        @(negedge clk);
        hwrite[d] = 1'b0;
        while (!rdy[d] && lows < 40) begin
            hwdata[d] = 32'hA5A5_0000 | 32'($urandom_range(0, 16'hFFFF));
            lows++;
            @(negedge clk);
        end
        hwdata[d] = 32'h1234_5678;
        chk("b2b write wait", lows, d * 3);
        @(negedge clk);
        idle_bus(d);
        hwdata[d] = $urandom;
        lows = 0;
        while (!rdy[d] && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        chk("b2b read wait", lows, d * 3);
        chk("b2b read rdata", rdata[d], 32'h1234_5678);
        mwrite(d, 32'h8, 3'd2, 32'h1234_5678);
    endtask
    task automatic rst_mid(int d);
        logic [31:0] p = mread(d, 32'h4);
        @(negedge clk);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = 32'h4; hwrite[d] = 1'b1; hsize[d] = 3'd2;
        @(negedge clk);
        idle_bus(d);
        hwdata[d] = ~p;
        rst[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b0;
        chk("reset-mid ready", 32'(rdy[d]), 32'd1);
        chk("reset-mid resp", resp[d], 0);
        chk("reset-mid rdata", rdata[d], 0);
        xfer(d, 1'b0, 32'h4, 3'd2, 32'h0, p, "reset-mid readback");
    endtask
    vec_t        tbl [$];
    bit          wr;
    logic [31:0] a, w;
    logic [2:0]  s;
    initial begin
        tbl.push_back('{1'b1, 32'h10,  3'd2, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{1'b0, 32'h10,  3'd2, 32'h0,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, 32'h20,  3'd2, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 32'h21,  3'd0, 32'h0000_1100, 32'h0});
        tbl.push_back('{1'b1, 32'h23,  3'd0, 32'h2200_0000, 32'h0});
        tbl.push_back('{1'b0, 32'h20,  3'd2, 32'h0,         32'h2200_1100});
        tbl.push_back('{1'b0, 32'h22,  3'd0, 32'h0,         32'h2200_1100});
        tbl.push_back('{1'b1, 32'h22,  3'd1, 32'hABCD_0000, 32'h0});
        tbl.push_back('{1'b0, 32'h20,  3'd2, 32'h0,         32'hABCD_1100});
        tbl.push_back('{1'b1, 32'h0,   3'd2, 32'h0102_0304, 32'h0});
        tbl.push_back('{1'b1, 32'h400, 3'd2, 32'h5555_5555, 32'h0});
        tbl.push_back('{1'b0, 32'h0,   3'd2, 32'h0, ERR_EN ? 32'h0102_0304 : 32'h5555_5555});
        tbl.push_back('{1'b0, 32'h1,   3'd1, 32'h0, ERR_EN ? 32'h0102_0304 : 32'h5555_5555});
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = 32'h0;
            hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset ready", 32'(rdy[d]), 32'd1);
            chk("reset resp", resp[d], 0);
            chk("reset rdata", rdata[d], 0);
            rst[d] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++)
                xfer(d, 1'b1, 32'(4 * i), 3'd2, $urandom, 32'h0, "init");
            foreach (tbl[i])
                xfer(d, tbl[i].wr, tbl[i].a, tbl[i].s, tbl[i].w, tbl[i].rd, $sformatf("vec%0d", i));
            burst(d);
            b2b(d);
            rst_mid(d);
            for (int i = 0; i < 60; i++) begin
                wr = 1'($urandom_range(0, 1));
                a  = 32'($urandom_range(0, 127)) + ($urandom_range(0, 3) == 0 ? 32'h400 : 32'h0);
                s  = 3'($urandom_range(0, 3));
                w  = $urandom;
                xfer(d, wr, a, s, w, wr ? 32'h0 : mread(d, a), $sformatf("rand%0d", i));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
